// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and data-port accesses onto one variable-latency memory bus.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              start_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              stall_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ack_i,
    output logic              timeout_o
);
    localparam int               CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                if_ready_q, if_ready_d;
    logic [DATA_W-1:0]   mem_rdata_q, mem_rdata_d;
    logic                mem_ready_q, mem_ready_d;
    logic                bus_req_q, bus_req_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
    logic                timeout_q, timeout_d;

    logic in_idle, if_elig, mem_elig, grant_mem, grant_if, ack_valid;

    // A port whose ready pulse is showing this cycle must not be granted again.
    assign in_idle   = (state_q == IDLE);
    assign if_elig   = if_req_i & ~if_ready_q;
    assign mem_elig  = mem_req_i & ~mem_ready_q;
    assign ack_valid = bus_ack_i & bus_req_q;

`ifdef MEM_ARB_RR_EN
    logic last_owner_q, last_owner_d;  // 1 = data port granted last

    assign grant_mem    = in_idle & mem_elig & (~if_elig | ~last_owner_q);
    assign last_owner_d = grant_mem ? 1'b1 : (grant_if ? 1'b0 : last_owner_q);
`else
    assign grant_mem = in_idle & mem_elig;
`endif
    assign grant_if = in_idle & if_elig & ~grant_mem;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        mem_ready_d = 1'b0;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d     = MEM_WAIT;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we_i;
                    bus_addr_d  = mem_addr_i;
                    bus_wdata_d = mem_wdata_i;
                end else if (grant_if) begin
                    state_d     = IF_WAIT;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr_i;
                    bus_wdata_d = '0;
                end
            end
            IF_WAIT, MEM_WAIT: begin
                if (ack_valid) begin
                    if (state_q == IF_WAIT) begin
                        if_rdata_d = bus_rdata_i;
                        if_ready_d = 1'b1;
                    end else begin
                        if (!bus_we_q) mem_rdata_d = bus_rdata_i;
                        mem_ready_d = 1'b1;
                    end
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Abort: complete the access with zero data and flag it permanently.
                    if (state_q == IF_WAIT) begin
                        if_rdata_d = '0;
                        if_ready_d = 1'b1;
                    end else begin
                        mem_rdata_d = '0;
                        mem_ready_d = 1'b1;
                    end
                    timeout_d = 1'b1;
                    bus_req_d = 1'b0;
                    bus_we_d  = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            if_rdata_q   <= '0;
            if_ready_q   <= 1'b0;
            mem_rdata_q  <= '0;
            mem_ready_q  <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            timeout_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            if_rdata_q   <= if_rdata_d;
            if_ready_q   <= if_ready_d;
            mem_rdata_q  <= mem_rdata_d;
            mem_ready_q  <= mem_ready_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            timeout_q    <= timeout_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    assign if_rdata_o  = if_rdata_q;
    assign if_ready_o  = if_ready_q;
    assign mem_rdata_o = mem_rdata_q;
    assign mem_ready_o = mem_ready_q;
    assign bus_req_o   = bus_req_q;
    assign bus_we_o    = bus_we_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign timeout_o   = timeout_q;

    // Held low during reset so a reset pipeline never sees a stall.
    assign stall_o = start_i & ((if_req_i & ~if_ready_q) | (mem_req_i & ~mem_ready_q));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized transactions
// against a transaction-level model (grant order, latency, returned data, sticky timeout).
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;
`ifdef MEM_ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              start_i = 1'b0;
    logic              if_req_i = 1'b0;
    logic [ADDR_W-1:0] if_addr_i = '0;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ready_o;
    logic              mem_req_i = 1'b0;
    logic              mem_we_i = 1'b0;
    logic [ADDR_W-1:0] mem_addr_i = '0;
    logic [DATA_W-1:0] mem_wdata_i = '0;
    logic [DATA_W-1:0] mem_rdata_o;
    logic              mem_ready_o;
    logic              stall_o;
    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic [DATA_W-1:0] bus_rdata_i = '0;
    logic              bus_ack_i = 1'b0;
    logic              timeout_o;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk_i), .start_i(start_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ready_o(if_ready_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ready_o(mem_ready_o),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
        .timeout_o(timeout_o)
    );

    typedef struct {
        bit                is_mem;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        int                delay;  // bus cycles without ack before the ack cycle
        bit                abort;  // never ack
    } txn_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [DATA_W-1:0] exp_if_rdata  = '0;
    logic [DATA_W-1:0] exp_mem_rdata = '0;
    bit                exp_timeout   = 1'b0;
    bit                last_mem      = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drop_req(input bit is_mem);
        if (is_mem) mem_req_i = 1'b0;
        else        if_req_i  = 1'b0;
    endtask

    function automatic txn_t rand_txn(input bit is_mem);
        txn_t t;
        int   r;
        t.is_mem = is_mem;
        t.we     = is_mem ? bit'($urandom_range(0, 1)) : 1'b0;
        t.addr   = $urandom;
        t.wdata  = $urandom;
        t.rdata  = $urandom;
        r        = $urandom_range(0, 9);
        t.abort  = (r == 0);
        t.delay  = (r == 1) ? MAX_WAIT - 1 : $urandom_range(0, 4);
        return t;
    endfunction

    // Entered in the first cycle bus_req_o should be high; returns one cycle after the ready pulse.
    task automatic serve(input txn_t t, input bit other_pending, input bit hold, input string tag);
        int n_wait;
        check({tag, " bus_req_rise"}, bus_req_o, 1'b1);
        if (bus_req_o !== 1'b1) return;
        last_mem = t.is_mem;
        n_wait   = t.abort ? MAX_WAIT : t.delay;
        for (int i = 0; i < n_wait; i++) begin
            check({tag, " bus_req_held"}, bus_req_o, 1'b1);
            check({tag, " bus_addr"}, bus_addr_o, t.addr);
            check({tag, " bus_we"}, bus_we_o, t.is_mem & t.we);
            if (t.is_mem && t.we) check({tag, " bus_wdata"}, bus_wdata_o, t.wdata);
            check({tag, " no_early_ready"}, {if_ready_o, mem_ready_o}, 2'b00);
            check({tag, " stall_wait"}, stall_o, 1'b1);
            tick();
        end
        if (!t.abort) begin
            check({tag, " bus_req_ack_cycle"}, bus_req_o, 1'b1);
            check({tag, " bus_addr_ack_cycle"}, bus_addr_o, t.addr);
            bus_ack_i   = 1'b1;
            bus_rdata_i = t.rdata;
            tick();
            bus_ack_i   = 1'b0;
            bus_rdata_i = $urandom;
        end
        if (t.abort) begin
            exp_timeout = 1'b1;
            if (t.is_mem) exp_mem_rdata = '0;
            else          exp_if_rdata  = '0;
        end else if (!(t.is_mem && t.we)) begin
            if (t.is_mem) exp_mem_rdata = t.rdata;
            else          exp_if_rdata  = t.rdata;
        end
        check({tag, " ready_pulse"}, {if_ready_o, mem_ready_o}, t.is_mem ? 2'b01 : 2'b10);
        check({tag, " if_rdata"}, if_rdata_o, exp_if_rdata);
        check({tag, " mem_rdata"}, mem_rdata_o, exp_mem_rdata);
        check({tag, " timeout"}, timeout_o, exp_timeout);
        check({tag, " bus_req_fall"}, bus_req_o, 1'b0);
        check({tag, " bus_we_fall"}, bus_we_o, 1'b0);
        check({tag, " stall_ready"}, stall_o, other_pending);
        if (!hold) drop_req(t.is_mem);
        tick();
        check({tag, " ready_one_cycle"}, {if_ready_o, mem_ready_o}, 2'b00);
        check({tag, " rdata_held"}, t.is_mem ? mem_rdata_o : if_rdata_o,
              t.is_mem ? exp_mem_rdata : exp_if_rdata);
        if (!other_pending) check({tag, " no_reserve"}, bus_req_o, 1'b0);
        if (hold) drop_req(t.is_mem);
    endtask

    task automatic trial(input bit do_if, input bit do_mem, input txn_t ti, input txn_t tm,
                         input bit hold, input string tag);
        bit mem_first;
        if (do_if) begin
            if_req_i  = 1'b1;
            if_addr_i = ti.addr;
        end
        if (do_mem) begin
            mem_req_i   = 1'b1;
            mem_we_i    = tm.we;
            mem_addr_i  = tm.addr;
            mem_wdata_i = tm.wdata;
        end
        #1;
        check({tag, " stall_cycle0"}, stall_o, do_if | do_mem);
        check({tag, " bus_idle_cycle0"}, bus_req_o, 1'b0);
        mem_first = do_mem && (!do_if || !RR_MODE || !last_mem);
        tick();
        if (mem_first) begin
            serve(tm, do_if, hold, {tag, " mem"});
            if (do_if) serve(ti, 1'b0, hold, {tag, " if"});
        end else begin
            serve(ti, do_mem, hold, {tag, " if"});
            if (do_mem) serve(tm, 1'b0, hold, {tag, " mem"});
        end
        tick();
        check({tag, " idle_after"}, bus_req_o, 1'b0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

    initial begin
        txn_t ti, tm;
        bit   di, dm;

        // Reset state, with requests present to confirm stall stays low.
        if_req_i  = 1'b1;
        mem_req_i = 1'b1;
        tick();
        check("reset bus", {bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o}, '0);
        check("reset rdata", {if_rdata_o, mem_rdata_o}, '0);
        check("reset ready_timeout", {if_ready_o, mem_ready_o, timeout_o}, 3'b000);
        check("reset stall", stall_o, 1'b0);
        if_req_i  = 1'b0;
        mem_req_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();

        // Fetch, ack in first bus cycle, request held through the ready cycle.
        ti = '{is_mem: 1'b0, we: 1'b0, addr: 32'h40, wdata: '0, rdata: 32'h00A00093,
               delay: 0, abort: 1'b0};
        trial(1'b1, 1'b0, ti, ti, 1'b1, "t1");

        // Load to give mem_rdata a value, then a store that must leave it alone.
        tm = '{is_mem: 1'b1, we: 1'b0, addr: 32'h20, wdata: '0, rdata: 32'hDEADBEEF,
               delay: 1, abort: 1'b0};
        trial(1'b0, 1'b1, tm, tm, 1'b0, "t2load");
        tm = '{is_mem: 1'b1, we: 1'b1, addr: 32'h10, wdata: 32'h55, rdata: 32'h12345678,
               delay: 2, abort: 1'b0};
        trial(1'b0, 1'b1, tm, tm, 1'b0, "t2store");

        // Simultaneous requests.
        ti = '{is_mem: 1'b0, we: 1'b0, addr: 32'h44, wdata: '0, rdata: 32'hA1A1A1A1,
               delay: 1, abort: 1'b0};
        tm = '{is_mem: 1'b1, we: 1'b0, addr: 32'h84, wdata: '0, rdata: 32'hB2B2B2B2,
               delay: 0, abort: 1'b0};
        trial(1'b1, 1'b1, ti, tm, 1'b0, "t3");

        // Abort with no ack, then a good access with timeout still set.
        ti = '{is_mem: 1'b0, we: 1'b0, addr: 32'h48, wdata: '0, rdata: 32'hFFFFFFFF,
               delay: 0, abort: 1'b1};
        trial(1'b1, 1'b0, ti, ti, 1'b0, "t4abort");
        tm = '{is_mem: 1'b1, we: 1'b0, addr: 32'h90, wdata: '0, rdata: 32'h0BADF00D,
               delay: MAX_WAIT - 1, abort: 1'b0};
        trial(1'b0, 1'b1, tm, tm, 1'b0, "t4after");

        // Reset while in MEM_WAIT, coinciding with an ack.
        mem_req_i  = 1'b1;
        mem_we_i   = 1'b0;
        mem_addr_i = 32'h80;
        tick();
        check("t5 granted", bus_req_o, 1'b1);
        tick();
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'hCAFEBABE;
        start_i     = 1'b0;
        #1;
        check("t5 bus_req_drop", bus_req_o, 1'b0);
        check("t5 no_ready", {if_ready_o, mem_ready_o}, 2'b00);
        check("t5 timeout_cleared", timeout_o, 1'b0);
        check("t5 rdata_cleared", {if_rdata_o, mem_rdata_o}, '0);
        check("t5 stall_in_reset", stall_o, 1'b0);
        exp_if_rdata  = '0;
        exp_mem_rdata = '0;
        exp_timeout   = 1'b0;
        last_mem      = 1'b0;
        tick();
        bus_ack_i = 1'b0;
        check("t5 no_ready_after_ack", mem_ready_o, 1'b0);
        start_i = 1'b1;
        tick();
        tm = '{is_mem: 1'b1, we: 1'b0, addr: 32'h80, wdata: '0, rdata: 32'h13572468,
               delay: 1, abort: 1'b0};
        serve(tm, 1'b0, 1'b0, "t5 regrant");
        tick();
        check("t5 idle_after", bus_req_o, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            di = bit'($urandom_range(0, 1));
            dm = bit'($urandom_range(0, 1));
            if (!di && !dm) di = 1'b1;
            ti = rand_txn(1'b0);
            tm = rand_txn(1'b1);
            trial(di, dm, ti, tm, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
